// File: rtl/scr1_dmem_port_sel_pkg.sv
// Shared memory-interface types and widths for the data-memory port selector.
// Encodings follow the common SCR1 memif header so both ports speak the same protocol.
package scr1_dmem_port_sel_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // A response that completes the outstanding transaction, good or bad.
  function automatic logic scr1_mem_resp_done(input type_scr1_mem_resp_e resp);
    return (resp == SCR1_MEM_RESP_RDY_OK) || (resp == SCR1_MEM_RESP_RDY_ER);
  endfunction

endpackage

// File: rtl/scr1_dmem_port_sel.sv
// Routes LSU data-memory requests to one of two ports by address and returns the
// response of the port that owns the single outstanding transaction.
module scr1_dmem_port_sel
  import scr1_dmem_port_sel_pkg::*;
#(
  parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_MASK    = 32'hFFFF_0000,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_PATTERN = 32'h0048_0000
) (
  input  logic                        rst_n,
  input  logic                        clk,
  // LSU side
  input  logic                        dmem_req,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic                        dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp,
  // Port 0 (default)
  input  logic                        port0_req_ack,
  output logic                        port0_req,
  output type_scr1_mem_cmd_e          port0_cmd,
  output type_scr1_mem_width_e        port0_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] port0_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0] port0_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0] port0_rdata,
  input  type_scr1_mem_resp_e         port0_resp,
  // Port 1 (address-decoded window)
  input  logic                        port1_req_ack,
  output logic                        port1_req,
  output type_scr1_mem_cmd_e          port1_cmd,
  output type_scr1_mem_width_e        port1_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] port1_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0] port1_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0] port1_rdata,
  input  type_scr1_mem_resp_e         port1_resp
);

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_WAIT = 1'b1
  } fsm_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_e;

  fsm_e                        fsm, fsm_nxt;
  port_sel_e                   sel_r, sel_r_nxt, sel_nxt;
  logic                        req_allowed;
  logic                        sel_nxt_req_ack;
  logic                        req_accepted;
  type_scr1_mem_resp_e         sel_r_resp;
  logic [SCR1_DMEM_DWIDTH-1:0] sel_r_rdata;

  assign sel_nxt = ((dmem_addr & SCR1_PORT1_ADDR_MASK) == SCR1_PORT1_ADDR_PATTERN)
                 ? PORT1 : PORT0;

  assign sel_r_resp      = (sel_r == PORT1) ? port1_resp  : port0_resp;
  assign sel_r_rdata     = (sel_r == PORT1) ? port1_rdata : port0_rdata;
  assign sel_nxt_req_ack = (sel_nxt == PORT1) ? port1_req_ack : port0_req_ack;

  // A new request may issue when idle, or in the very cycle the owner completes.
  assign req_allowed  = (fsm == FSM_IDLE) || scr1_mem_resp_done(sel_r_resp);
  assign dmem_req_ack = dmem_req & req_allowed & sel_nxt_req_ack;
  assign req_accepted = dmem_req & dmem_req_ack;

  assign port0_req = dmem_req & (sel_nxt == PORT0) & req_allowed;
  assign port1_req = dmem_req & (sel_nxt == PORT1) & req_allowed;

  assign port0_cmd   = dmem_cmd;
  assign port0_width = dmem_width;
  assign port0_addr  = dmem_addr;
  assign port0_wdata = dmem_wdata;
  assign port1_cmd   = dmem_cmd;
  assign port1_width = dmem_width;
  assign port1_addr  = dmem_addr;
  assign port1_wdata = dmem_wdata;

  assign dmem_resp  = (fsm == FSM_WAIT) ? sel_r_resp  : SCR1_MEM_RESP_NOTRDY;
  assign dmem_rdata = (fsm == FSM_WAIT) ? sel_r_rdata : '0;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    fsm_nxt   = fsm;
    sel_r_nxt = sel_r;
    if (req_accepted) begin
      fsm_nxt   = FSM_WAIT;
      sel_r_nxt = sel_nxt;
    end else if ((fsm == FSM_WAIT) && scr1_mem_resp_done(sel_r_resp)) begin
      fsm_nxt = FSM_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      fsm   <= FSM_IDLE;
      sel_r <= PORT0;
    end else begin
      fsm   <= fsm_nxt;
      sel_r <= sel_r_nxt;
    end
  end

`ifdef SCR1_SIM_ENV
  a_req_known:  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(dmem_req));
  a_fsm_known:  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(fsm));
  a_sel_known:  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(sel_r));
  a_req_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                                 $onehot0({port1_req, port0_req}));
`endif

endmodule

// File: doc/scr1_dmem_port_sel.md
SCR1_DMEM_PORT_SEL -- requirements
Module: scr1_dmem_port_sel

Interface
REQ-001 The block SHALL have parameter SCR1_PORT1_ADDR_MASK, default 32'hFFFF_0000, address bits compared for port 1.
REQ-002 The block SHALL have parameter SCR1_PORT1_ADDR_PATTERN, default 32'h0048_0000, value the masked address must equal to select port 1.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 The block SHALL have port dmem_req, input, 1, request from the LSU side.
REQ-006 The block SHALL have port dmem_cmd, input, type_scr1_mem_cmd_e, RD or WR.
REQ-007 The block SHALL have port dmem_width, input, type_scr1_mem_width_e, BYTE, HWORD or WORD.
REQ-008 The block SHALL have port dmem_addr, input, SCR1_DMEM_AWIDTH, request address.
REQ-009 The block SHALL have port dmem_wdata, input, SCR1_DMEM_DWIDTH, store data.
REQ-010 The block SHALL have port dmem_req_ack, output, 1, request accepted by the selected port.
REQ-011 The block SHALL have port dmem_rdata, output, SCR1_DMEM_DWIDTH, load data.
REQ-012 The block SHALL have port dmem_resp, output, type_scr1_mem_resp_e, response to the LSU side.
REQ-013 The block SHALL have ports portX_req, output, 1, request to port X, for X = 0 and 1.
REQ-014 The block SHALL have ports portX_cmd, portX_width, portX_addr and portX_wdata, outputs, widths as for dmem_*, for X = 0 and 1.
REQ-015 The block SHALL have ports portX_req_ack, input, 1, and portX_rdata, input, SCR1_DMEM_DWIDTH, for X = 0 and 1.
REQ-016 The block SHALL have ports portX_resp, input, type_scr1_mem_resp_e, for X = 0 and 1.

Function
REQ-017 The address decode SHALL be combinational: sel_nxt = PORT1 when (dmem_addr & MASK) == PATTERN, otherwise PORT0 (default port).
REQ-018 portX_cmd, portX_width, portX_addr and portX_wdata SHALL be driven from dmem_* on both ports unconditionally.
REQ-019 portX_req SHALL be dmem_req & (sel_nxt == X) & req_allowed, and at most one port_req SHALL be high in any cycle.
REQ-020 The FSM SHALL have two states: IDLE (no outstanding transaction) and WAIT (one outstanding transaction on port sel_r).
REQ-021 req_allowed SHALL be 1 in IDLE, and in WAIT only in the cycle where the portsel_r response is RDY_OK or RDY_ER.
REQ-022 dmem_req_ack SHALL be req_allowed & portsel_nxt_req_ack.
REQ-023 On dmem_req & dmem_req_ack the FSM SHALL go to (or stay in) WAIT and set sel_r <= sel_nxt; this covers the back-to-back case in the response cycle.
REQ-024 In WAIT, on a RDY_OK or RDY_ER response without a new accepted request, the FSM SHALL go to IDLE.
REQ-025 In WAIT, dmem_resp and dmem_rdata SHALL mirror portsel_r_resp and portsel_r_rdata.
REQ-026 In IDLE, dmem_resp SHALL be NOTRDY and dmem_rdata SHALL be 0.
REQ-027 A response from the non-selected port SHALL be ignored and never forwarded.
REQ-028 A RDY_ER response SHALL be forwarded unchanged, with no retry, and SHALL end the transaction.
REQ-029 The block SHALL have zero added latency: request and response paths are combinational, and only sel_r and the FSM are registered.
REQ-030 A dmem_req that is not acked SHALL leave the state unchanged; the requester holds its inputs.

Reset
REQ-031 On rst_n low, asynchronously, the FSM SHALL go to IDLE and sel_r SHALL be PORT0.
REQ-032 During and after reset, all portX_req and dmem_req_ack SHALL be 0 unless dmem_req is asserted, and dmem_resp SHALL be NOTRDY.
REQ-033 A reset applied in WAIT SHALL abandon the outstanding transaction; a later stale port response seen in IDLE SHALL be ignored.

Structure
REQ-034 type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e SHALL come from the shared memif header.
REQ-035 The local FSM enum and the port-select enum SHALL be declared inside the module.
REQ-036 The block SHALL be a single module with no sub-module.
REQ-037 Assertions SHALL be guarded by SCR1_SIM_ENV: no X on dmem_req, FSM or sel_r; onehot0 on portX_req.

Verification
REQ-038 Reset: with rst_n low, the bench SHALL check dmem_resp = NOTRDY, port0_req = port1_req = 0, dmem_rdata = 0.
REQ-039 Port 1 load: LW at 0x0048_0010, port1_req_ack = 1, 2 cycles later port1_resp = RDY_OK with rdata 0xDEAD_BEEF; the bench SHALL check port1_req = 1, port0_req = 0, dmem_rdata = 0xDEAD_BEEF, then IDLE.
REQ-040 Port 0 store error: SW at 0x0000_0100, port0_resp = RDY_ER; the bench SHALL check dmem_resp = RDY_ER, the FSM returns to IDLE and port1 is untouched.
REQ-041 Back-to-back: in the cycle port0 returns RDY_OK, issue a request to 0x0048_0000; the bench SHALL check port1_req = 1 the same cycle, sel_r = PORT1 next cycle, with no bubble.
REQ-042 Stale response: in WAIT on port 0, inject port1_resp = RDY_OK; the bench SHALL check dmem_resp = NOTRDY; then port0 RDY_OK is forwarded.
REQ-043 Reset mid-operation: assert rst_n low in WAIT; the bench SHALL check the FSM is IDLE, a later port0_resp RDY_OK gives dmem_resp = NOTRDY, and a new request is accepted.
